// File: rtl/adapter_rx_pcs_mf.sv
// Receive PCS adapter: MFI flywheel (HUNT/PRESYNC/SYNC), payload forwarding and
// CARD/SSF overhead extraction. Define ADAPTER_RX_PCS_ACCEPT_EN for the persistence filter.
module adapter_rx_pcs_mf #(
   parameter int MF_LEN   = 256,
   parameter int CH_N     = 16,
   parameter int DAT_W    = 6,
   parameter int CARD_POS = 28,
   parameter int CARD_W   = 4,
   parameter int SSF_POS  = 40,
   parameter int SSF_STEP = 8,
   parameter int SSF_W    = 7,
   parameter int SSF_GRP  = 6,
   parameter int LOCK_N   = 4,
   parameter int LOSS_N   = 3,
   parameter int ACC_N    = 3
) (
   input  logic                         Ck_77,
   input  logic                         Rs_n,
   input  logic                         Rx_PCS_Vld,
   input  logic [$clog2(MF_LEN)-1:0]    Rx_PCS_MFI,
   input  logic                         Rx_PCS_SH_Res,
   input  logic [DAT_W-1:0]             Rx_PCS_Dat,
   output logic [$clog2(CH_N)-1:0]      E1_Cha,
   output logic [DAT_W-1:0]             TX_DV_Dat,
   output logic                         TX_DV_Vld,
   output logic [CARD_W-1:0]            CARD_TYPE,
   output logic [SSF_GRP*SSF_W-1:0]     SSF,
   output logic                         Card_Chg,
   output logic                         SSF_Chg,
   output logic                         Mf_Lock,
   output logic                         Mf_Err
);

   localparam int MFI_W   = $clog2(MF_LEN);
   localparam int CH_W    = $clog2(CH_N);
   localparam int CAP_W   = (CARD_W > SSF_W) ? CARD_W : SSF_W;
   localparam int NFLD    = SSF_GRP + 1;
   localparam int FLD_W   = $clog2(NFLD);
   localparam int CNT_MAX = (LOCK_N > LOSS_N) ? ((LOCK_N > ACC_N) ? LOCK_N : ACC_N)
                                              : ((LOSS_N > ACC_N) ? LOSS_N : ACC_N);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [MFI_W-1:0] MFI_ONE   = MFI_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOCK_C    = CNT_W'(LOCK_N);
   localparam logic [CNT_W-1:0] LOSS_C    = CNT_W'(LOSS_N);
   localparam logic [CAP_W-1:0] CARD_MASK = CAP_W'((1 << CARD_W) - 1);
   localparam logic [CAP_W-1:0] SSF_MASK  = CAP_W'((1 << SSF_W) - 1);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PRESYNC = 2'd1,
      ST_SYNC    = 2'd2
   } state_t;

   state_t             state_q;
   logic [MFI_W-1:0]   ref_q;
   logic [CNT_W-1:0]   good_cnt_q;
   logic [CNT_W-1:0]   bad_cnt_q;
   logic [CH_W-1:0]    cha_q;
   logic [DAT_W-1:0]   dat_q;
   logic               vld_q;
   logic               lock_q;
   logic               err_q;
   logic [CAP_W-2:0]   sr_q;
   logic               clean_q;
   logic               card_chg_q;
   logic               ssf_chg_q;
   logic [CAP_W-1:0]   out_q [NFLD];
`ifdef ADAPTER_RX_PCS_ACCEPT_EN
   localparam logic [CNT_W-1:0] ACC_C = CNT_W'(ACC_N);
   logic [CAP_W-1:0]   cand_q [NFLD];
   logic [CNT_W-1:0]   cnt_q  [NFLD];
   logic [CNT_W-1:0]   cnt_new_s;
`endif

   logic [MFI_W-1:0]   exp_s;
   logic               good_s;
   logic               in_sync_s;
   logic               fld_hit_s;
   logic               fld_start_s;
   logic               fld_last_s;
   logic [FLD_W-1:0]   fld_s;
   logic [CAP_W-1:0]   cap_s;
   logic [CAP_W-1:0]   cap_fld_s;
   logic               offer_s;
   logic               accept_s;
   int                 pos_i;
   int                 grp_s;

   // Expected MFI and field decode at the flywheel position of this beat
   always_comb begin
      exp_s       = ref_q + MFI_ONE;
      good_s      = (Rx_PCS_MFI == exp_s);
      in_sync_s   = (state_q == ST_SYNC);
      pos_i       = int'(exp_s);
      grp_s       = 0;
      fld_hit_s   = 1'b0;
      fld_start_s = 1'b0;
      fld_last_s  = 1'b0;
      fld_s       = '0;
      if (pos_i >= CARD_POS && pos_i < CARD_POS + CARD_W) begin
         fld_hit_s   = 1'b1;
         fld_start_s = (pos_i == CARD_POS);
         fld_last_s  = (pos_i == CARD_POS + CARD_W - 1);
      end else begin
         for (int g = 0; g < SSF_GRP; g++) begin
            grp_s = SSF_POS + g * SSF_STEP;
            if (pos_i >= grp_s && pos_i < grp_s + SSF_W) begin
               fld_hit_s   = 1'b1;
               fld_start_s = (pos_i == grp_s);
               fld_last_s  = (pos_i == grp_s + SSF_W - 1);
               fld_s       = FLD_W'(g + 1);
            end else begin
               fld_s = fld_s;
            end
         end
      end
   end

   // Capture value and acceptance decision for the field ending on this beat
   always_comb begin
      cap_s     = {sr_q, Rx_PCS_SH_Res};
      cap_fld_s = cap_s & ((fld_s == '0) ? CARD_MASK : SSF_MASK);
      offer_s   = Rx_PCS_Vld & in_sync_s & fld_hit_s & fld_last_s & good_s
                  & (fld_start_s | clean_q);
`ifdef ADAPTER_RX_PCS_ACCEPT_EN
      if (cap_fld_s == cand_q[fld_s]) begin
         cnt_new_s = (cnt_q[fld_s] >= ACC_C) ? ACC_C : cnt_q[fld_s] + CNT_ONE;
      end else begin
         cnt_new_s = CNT_ONE;
      end
      accept_s = (cnt_new_s == ACC_C) && (cap_fld_s != out_q[fld_s]);
`else
      accept_s = (cap_fld_s != out_q[fld_s]);
`endif
   end

   // Alignment FSM with registered payload, lock and error outputs
   always_ff @(posedge Ck_77 or negedge Rs_n) begin
      if (!Rs_n) begin
         state_q    <= ST_HUNT;
         ref_q      <= '0;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         cha_q      <= '0;
         dat_q      <= '0;
         vld_q      <= 1'b0;
         lock_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         vld_q <= 1'b0;
         if (Rx_PCS_Vld) begin
            cha_q <= Rx_PCS_MFI[CH_W-1:0];
            dat_q <= Rx_PCS_Dat;
            case (state_q)
               ST_HUNT: begin
                  ref_q <= Rx_PCS_MFI;
                  if (good_s) begin
                     good_cnt_q <= CNT_ONE;
                     if (CNT_ONE >= LOCK_C) begin
                        state_q <= ST_SYNC;
                        lock_q  <= 1'b1;
                        vld_q   <= 1'b1;
                     end else begin
                        state_q <= ST_PRESYNC;
                     end
                  end else begin
                     good_cnt_q <= '0;
                  end
               end
               ST_PRESYNC: begin
                  ref_q <= Rx_PCS_MFI;
                  if (good_s) begin
                     good_cnt_q <= good_cnt_q + CNT_ONE;
                     if (good_cnt_q + CNT_ONE >= LOCK_C) begin
                        state_q <= ST_SYNC;
                        lock_q  <= 1'b1;
                        vld_q   <= 1'b1;
                     end
                  end else begin
                     state_q    <= ST_HUNT;
                     good_cnt_q <= '0;
                  end
               end
               ST_SYNC: begin
                  // Flywheel: reference advances regardless of what was received
                  ref_q <= exp_s;
                  vld_q <= 1'b1;
                  if (!good_s) begin
                     err_q <= 1'b1;
                     if (bad_cnt_q + CNT_ONE >= LOSS_C) begin
                        state_q    <= ST_HUNT;
                        lock_q     <= 1'b0;
                        vld_q      <= 1'b0;
                        bad_cnt_q  <= '0;
                        good_cnt_q <= '0;
                     end else begin
                        bad_cnt_q <= bad_cnt_q + CNT_ONE;
                     end
                  end else begin
                     bad_cnt_q <= '0;
                  end
               end
               default: begin
                  state_q <= ST_HUNT;
                  lock_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Field shift register, cleanliness tracking and accepted outputs
   always_ff @(posedge Ck_77 or negedge Rs_n) begin
      if (!Rs_n) begin
         sr_q       <= '0;
         clean_q    <= 1'b0;
         card_chg_q <= 1'b0;
         ssf_chg_q  <= 1'b0;
         for (int i = 0; i < NFLD; i++) begin
            out_q[i] <= '0;
`ifdef ADAPTER_RX_PCS_ACCEPT_EN
            cand_q[i] <= '0;
            cnt_q[i]  <= '0;
`endif
         end
      end else begin
         card_chg_q <= offer_s & accept_s & (fld_s == '0);
         ssf_chg_q  <= offer_s & accept_s & (fld_s != '0);
         if (Rx_PCS_Vld && !in_sync_s) begin
            clean_q <= 1'b0;
         end else if (Rx_PCS_Vld && fld_hit_s) begin
            sr_q    <= cap_s[CAP_W-2:0];
            clean_q <= (fld_start_s | clean_q) & good_s;
         end
         if (offer_s) begin
`ifdef ADAPTER_RX_PCS_ACCEPT_EN
            cand_q[fld_s] <= cap_fld_s;
            cnt_q[fld_s]  <= cnt_new_s;
`endif
            if (accept_s) begin
               out_q[fld_s] <= cap_fld_s;
            end
         end
      end
   end

   for (genvar g = 0; g < SSF_GRP; g++) begin : g_ssf
      assign SSF[g*SSF_W +: SSF_W] = out_q[g+1][SSF_W-1:0];
   end

   assign CARD_TYPE = out_q[0][CARD_W-1:0];
   assign E1_Cha    = cha_q;
   assign TX_DV_Dat = dat_q;
   assign TX_DV_Vld = vld_q;
   assign Card_Chg  = card_chg_q;
   assign SSF_Chg   = ssf_chg_q;
   assign Mf_Lock   = lock_q;
   assign Mf_Err    = err_q;

endmodule

// File: tb/tb_adapter_rx_pcs_mf.sv
// Scoreboard bench for adapter_rx_pcs_mf: random beats against a position-array reference model.
module tb_adapter_rx_pcs_mf;
   localparam int MF_LEN = 256, CH_N = 16, DAT_W = 6, CARD_POS = 28, CARD_W = 4;
   localparam int SSF_POS = 40, SSF_STEP = 8, SSF_W = 7, SSF_GRP = 6;
   localparam int LOCK_N = 4, LOSS_N = 3, ACC_N = 3, NF = SSF_GRP + 1;

   logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0, sh = 1'b0;
   logic [7:0] mfi = 8'd0;
   logic [5:0] dat = 6'd0;
   logic [3:0] e1_cha;
   logic [5:0] tx_dat;
   logic tx_vld, card_chg, ssf_chg, mf_lock, mf_err;
   logic [3:0] card_type;
   logic [41:0] ssf;

   adapter_rx_pcs_mf dut (
      .Ck_77(clk), .Rs_n(rst_n), .Rx_PCS_Vld(vld), .Rx_PCS_MFI(mfi),
      .Rx_PCS_SH_Res(sh), .Rx_PCS_Dat(dat), .E1_Cha(e1_cha), .TX_DV_Dat(tx_dat),
      .TX_DV_Vld(tx_vld), .CARD_TYPE(card_type), .SSF(ssf), .Card_Chg(card_chg),
      .SSF_Chg(ssf_chg), .Mf_Lock(mf_lock), .Mf_Err(mf_err)
   );

   always #6 clk = ~clk;

   typedef struct packed {
      logic        vld;
      logic [3:0]  cha;
      logic [5:0]  dat;
      logic        lock;
      logic        err;
      logic [3:0]  card;
      logic [41:0] ssf;
      logic        cchg;
      logic        schg;
   } exp_t;

   exp_t sb[$];
   exp_t cur_e;
   int n_cmp = 0, n_bad = 0;

   // reference model state: mode 0 hunt, 1 presync, 2 sync
   int m_mode, m_ref, m_good, m_bad;
   bit ok_at[MF_LEN];
   bit sh_at[MF_LEN];
   int m_out[NF];
   int fs[NF], fw[NF];
`ifdef ADAPTER_RX_PCS_ACCEPT_EN
   int hv[NF][ACC_N];
   int hn[NF];
`endif

   logic [3:0] card_pat;
   logic [6:0] ssf_pat[SSF_GRP];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic accept(input int f, input int val);
      bit take;
`ifdef ADAPTER_RX_PCS_ACCEPT_EN
      for (int k = ACC_N - 1; k > 0; k--) hv[f][k] = hv[f][k-1];
      hv[f][0] = val;
      if (hn[f] < ACC_N) hn[f]++;
      take = (hn[f] == ACC_N);
      for (int k = 0; k < ACC_N; k++) if (hv[f][k] != val) take = 1'b0;
`else
      take = 1'b1;
`endif
      if (take && val != m_out[f]) begin
         m_out[f] = val;
         if (f == 0) cur_e.cchg = 1'b1;
         else cur_e.schg = 1'b1;
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] m, input logic s, input logic [5:0] d);
      int ex, val;
      bit good, clean;
      cur_e.err  = 1'b0;
      cur_e.cchg = 1'b0;
      cur_e.schg = 1'b0;
      cur_e.vld  = 1'b0;
      if (v) begin
         ex   = (m_ref + 1) % MF_LEN;
         good = (int'(m) == ex);
         if (m_mode == 2) begin
            sh_at[ex] = s;
            ok_at[ex] = good;
            for (int f = 0; f < NF; f++) begin
               if (ex == fs[f] + fw[f] - 1) begin
                  clean = 1'b1;
                  val = 0;
                  for (int i = 0; i < fw[f]; i++) begin
                     clean = clean & ok_at[fs[f] + i];
                     val = val * 2 + int'(sh_at[fs[f] + i]);
                  end
                  if (clean) accept(f, val);
               end
            end
            m_ref = ex;
            if (!good) begin
               cur_e.err = 1'b1;
               m_bad++;
               if (m_bad >= LOSS_N) begin
                  m_mode = 0;
                  m_bad = 0;
               end
            end else begin
               m_bad = 0;
            end
         end else begin
            for (int i = 0; i < MF_LEN; i++) ok_at[i] = 1'b0;
            m_ref = int'(m);
            if (m_mode == 0) begin
               if (good) begin
                  m_good = 1;
                  m_mode = (m_good >= LOCK_N) ? 2 : 1;
               end
            end else if (good) begin
               m_good++;
               if (m_good >= LOCK_N) m_mode = 2;
            end else begin
               m_mode = 0;
            end
         end
         cur_e.vld = (m_mode == 2);
         cur_e.cha = m[3:0];
         cur_e.dat = d;
      end
      cur_e.lock = (m_mode == 2);
      cur_e.card = 4'(m_out[0]);
      for (int g = 0; g < SSF_GRP; g++) cur_e.ssf[g*SSF_W +: SSF_W] = 7'(m_out[g+1]);
      sb.push_back(cur_e);
   endtask

   function automatic logic sh_for(input int p);
      int s;
      if (p >= CARD_POS && p < CARD_POS + CARD_W) return card_pat[CARD_W - 1 - (p - CARD_POS)];
      for (int g = 0; g < SSF_GRP; g++) begin
         s = SSF_POS + g * SSF_STEP;
         if (p >= s && p < s + SSF_W) return ssf_pat[g][SSF_W - 1 - (p - s)];
      end
      return 1'($urandom % 2);
   endfunction

   // monitor: pop one expectation per sampled beat, #1 after the active edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("tx_vld", 64'(tx_vld), 64'(e.vld));
            chk("mf_lock", 64'(mf_lock), 64'(e.lock));
            chk("mf_err", 64'(mf_err), 64'(e.err));
            chk("card_type", 64'(card_type), 64'(e.card));
            chk("ssf", 64'(ssf), 64'(e.ssf));
            chk("card_chg", 64'(card_chg), 64'(e.cchg));
            chk("ssf_chg", 64'(ssf_chg), 64'(e.schg));
            if (e.vld) begin
               chk("e1_cha", 64'(e1_cha), 64'(e.cha));
               chk("tx_dat", 64'(tx_dat), 64'(e.dat));
            end
         end
      end
   end

   initial begin
      int p;
      bit v;
      logic [7:0] rx_m;
      m_mode = 0; m_ref = 0; m_good = 0; m_bad = 0;
      cur_e = '0;
      for (int f = 0; f < NF; f++) begin
         m_out[f] = 0;
         fs[f] = (f == 0) ? CARD_POS : SSF_POS + (f - 1) * SSF_STEP;
         fw[f] = (f == 0) ? CARD_W : SSF_W;
`ifdef ADAPTER_RX_PCS_ACCEPT_EN
         hn[f] = 0;
`endif
      end
      for (int i = 0; i < MF_LEN; i++) begin
         ok_at[i] = 1'b0;
         sh_at[i] = 1'b0;
      end
      card_pat = 4'hA;
      for (int g = 0; g < SSF_GRP; g++) ssf_pat[g] = 7'($urandom);
      ssf_pat[2] = 7'b1100101;

      repeat (3) @(negedge clk);
      chk("rst_tx_vld", 64'(tx_vld), 64'd0);
      chk("rst_lock", 64'(mf_lock), 64'd0);
      chk("rst_err", 64'(mf_err), 64'd0);
      chk("rst_card", 64'(card_type), 64'd0);
      chk("rst_ssf", 64'(ssf), 64'd0);
      chk("rst_card_chg", 64'(card_chg), 64'd0);
      chk("rst_ssf_chg", 64'(ssf_chg), 64'd0);
      chk("rst_cha", 64'(e1_cha), 64'd0);
      chk("rst_dat", 64'(tx_dat), 64'd0);
      rst_n = 1'b1;

      for (int mfn = 0; mfn < 28; mfn++) begin
         if (mfn >= 4) begin
            if ($urandom % 3 == 0) card_pat = 4'($urandom);
            for (int g = 0; g < SSF_GRP; g++) if ($urandom % 4 == 0) ssf_pat[g] = 7'($urandom);
         end
         p = 0;
         while (p < MF_LEN) begin
            @(negedge clk);
            v = ($urandom % 8 != 0);
            if (!v) rx_m = 8'($urandom);
            else if (mfn == 5 && p == 50) rx_m = 8'd90;
            else if (mfn == 12 && p >= 100 && p < 103) rx_m = 8'((p + 37) % MF_LEN);
            else if ($urandom % 700 == 0) rx_m = 8'((p + 1 + int'($urandom_range(1, 200))) % MF_LEN);
            else rx_m = 8'(p);
            vld = v;
            mfi = rx_m;
            sh  = sh_for(p);
            dat = 6'($urandom);
            model_step(v, mfi, sh, dat);
            if (v) p++;
         end
      end
      @(negedge clk);
      vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);

      // asynchronous reset in the middle of a clock phase
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_lock", 64'(mf_lock), 64'd0);
      chk("arst_card", 64'(card_type), 64'd0);
      chk("arst_ssf", 64'(ssf), 64'd0);
      chk("arst_tx_vld", 64'(tx_vld), 64'd0);
      chk("arst_cha", 64'(e1_cha), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
